instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Program counter and fetch sequencer for the miniMIPS instruction memory.
// Tracks the address of the instruction currently on the memory output and handles stalls, redirects and HALT.
module instr_fetch_unit #(
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [5:0]  redirect_target,
  input  logic [15:0] instruction,
  output logic [5:0]  read_adress,
  output logic [5:0]  instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALTED
  } state_t;

  state_t      state, state_next;
  logic [5:0]  pc, pc_next, instr_pc_next;
  logic        instr_valid_next, halted_next;
  logic [15:0] fetch_count_next, fetch_count_inc;
  logic        halt_hit;

  // While stalled or halted, the memory re-reads the displayed instruction so its output stays put.
  assign read_adress = (stall || state == S_HALTED) ? instr_pc : pc;

  assign fetch_count_inc = (fetch_count == 16'hFFFF) ? fetch_count : fetch_count + 16'd1;

  // Redirect outranks HALT: a HALT_WORD seen alongside a redirect is wrong-path.
  assign halt_hit = (state == S_RUN) && instr_valid && !stall && !redirect &&
                    (instruction == HALT_WORD);

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    halted_next      = halted;
    fetch_count_next = fetch_count;
    case (state)
      S_BOOT: begin
        // Memory output is undefined here, so any redirect is meaningless and ignored.
        if (!stall) begin
          instr_pc_next    = pc;
          pc_next          = pc + 6'd1;
          instr_valid_next = 1'b1;
          fetch_count_next = fetch_count_inc;
          state_next       = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_hit) begin
          halted_next      = 1'b1;
          instr_valid_next = 1'b0;
          state_next       = S_HALTED;
        end else if (!stall) begin
          instr_pc_next    = pc;
          pc_next          = redirect ? redirect_target : pc + 6'd1;
          instr_valid_next = !redirect;
          if (!redirect) fetch_count_next = fetch_count_inc;
        end
      end
      S_HALTED: instr_valid_next = 1'b0;
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
      halted      <= halted_next;
      fetch_count <= fetch_count_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table-driven cycle vectors with a fetch scoreboard,
// followed by hand-written asynchronous-reset sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [5:0]  redirect_target;
  logic [15:0] instruction;
  logic [5:0]  read_adress;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instruction     (instruction),
    .read_adress     (read_adress),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory image: word i holds i+1, except address 7 which holds HALT.
  logic [15:0] tb_mem [64];
  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = 16'(i + 1);
    tb_mem[7] = 16'hFFFF;
  end

  always @(posedge clk) instruction <= tb_mem[read_adress];

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [5:0]  target;
    logic [5:0]  exp_ra;
    logic [5:0]  exp_ipc;
    logic        exp_valid;
    logic        exp_halted;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic [5:0]  addr;
    logic [15:0] word;
  } fetch_t;

  vec_t   vecs[$];
  fetch_t sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic add(input logic s, input logic r, input logic [5:0] t, input logic [5:0] ra,
                     input logic [5:0] ipc, input logic v, input logic h, input logic [15:0] c);
    vec_t x;
    x = '{s, r, t, ra, ipc, v, h, c};
    vecs.push_back(x);
  endtask

  task automatic check_outputs(input string tag, input logic [5:0] ra, input logic [5:0] ipc,
                               input logic v, input logic h, input logic [15:0] c);
    check({tag, " read_adress"}, 32'(read_adress), 32'(ra));
    check({tag, " instr_pc"},    32'(instr_pc),    32'(ipc));
    check({tag, " instr_valid"}, 32'(instr_valid), 32'(v));
    check({tag, " halted"},      32'(halted),      32'(h));
    check({tag, " fetch_count"}, 32'(fetch_count), 32'(c));
  endtask

  initial begin
    fetch_t f;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

    //   stall red tgt  ra  ipc v h cnt
    add(0, 0,  0,  0,  0, 0, 0, 0);   // BOOT
    add(0, 0,  0,  1,  0, 1, 0, 1);
    add(0, 0,  0,  2,  1, 1, 0, 2);
    add(1, 0,  0,  2,  2, 1, 0, 3);   // three stall cycles at instr_pc=2
    add(1, 0,  0,  2,  2, 1, 0, 3);
    add(1, 0,  0,  2,  2, 1, 0, 3);
    add(0, 0,  0,  3,  2, 1, 0, 3);
    add(0, 0,  0,  4,  3, 1, 0, 4);
    add(0, 1, 40,  5,  4, 1, 0, 5);   // redirect to 40
    add(0, 0,  0, 40,  5, 0, 0, 5);
    add(0, 0,  0, 41, 40, 1, 0, 6);
    add(0, 1, 62, 42, 41, 1, 0, 7);   // redirect to 62, then wrap
    add(0, 0,  0, 62, 42, 0, 0, 7);
    add(0, 0,  0, 63, 62, 1, 0, 8);
    add(0, 0,  0,  0, 63, 1, 0, 9);
    add(0, 0,  0,  1,  0, 1, 0, 10);
    add(0, 0,  0,  2,  1, 1, 0, 11);
    add(0, 0,  0,  3,  2, 1, 0, 12);
    add(0, 0,  0,  4,  3, 1, 0, 13);
    add(0, 0,  0,  5,  4, 1, 0, 14);
    add(0, 0,  0,  6,  5, 1, 0, 15);
    add(0, 0,  0,  7,  6, 1, 0, 16);
    add(0, 1,  5,  8,  7, 1, 0, 17);  // HALT word with redirect: ignored
    add(0, 0,  0,  5,  8, 0, 0, 17);
    add(0, 0,  0,  6,  5, 1, 0, 18);
    add(0, 0,  0,  7,  6, 1, 0, 19);
    add(0, 0,  0,  8,  7, 1, 0, 20);  // HALT word valid: halts
    add(0, 0,  0,  7,  7, 0, 1, 20);
    add(0, 1, 20,  7,  7, 0, 1, 20);
    add(1, 0,  0,  7,  7, 0, 1, 20);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      stall = vecs[i].stall; redirect = vecs[i].redirect; redirect_target = vecs[i].target;
      #1;
      check_outputs(tag, vecs[i].exp_ra, vecs[i].exp_ipc, vecs[i].exp_valid,
                    vecs[i].exp_halted, vecs[i].exp_cnt);
      if (instr_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL %s scoreboard: valid output with no fetch expected", tag);
        end else begin
          f = sb.pop_front();
          check({tag, " sb addr"}, 32'(instr_pc), 32'(f.addr));
          check({tag, " sb word"}, 32'(instruction), 32'(f.word));
        end
      end
      if (i + 1 < vecs.size() && vecs[i+1].exp_valid) begin
        f.addr = vecs[i].exp_ra;
        f.word = tb_mem[vecs[i].exp_ra];
        sb.push_back(f);
      end
      @(negedge clk);
    end
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset while HALTED, away from any clock edge.
    #2 rst_n = 1'b0;
    #1 check_outputs("rst_halted", 6'd0, 6'd0, 1'b0, 1'b0, 16'd0);

    // BOOT holds under stall, then ignores redirect on its first advance.
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_target = 6'd30;
    #1 check_outputs("boot_stall", 6'd0, 6'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    stall = 1'b0;
    #1 check_outputs("boot_held", 6'd0, 6'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1 check_outputs("boot_redir_ignored", 6'd1, 6'd0, 1'b1, 1'b0, 16'd1);
    check("boot_redir_ignored instr", 32'(instruction), 32'h0001);
    @(negedge clk);
    stall = 1'b1;
    #1 check_outputs("pre_rst_stall", 6'd1, 6'd1, 1'b1, 1'b0, 16'd2);
    check("pre_rst_stall instr", 32'(instruction), 32'h0002);

    // Asynchronous reset in the middle of a stall.
    #2 rst_n = 1'b0;
    #1 check_outputs("rst_stall", 6'd0, 6'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    #1 check_outputs("restart_boot", 6'd0, 6'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    #1 check_outputs("restart_first", 6'd1, 6'd0, 1'b1, 1'b0, 16'd1);
    check("restart_first instr", 32'(instruction), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
